agc_gain_ctrl: RTL
==================

AGC_GAIN_CTRL -- requirements
Module: agc_gain_ctrl

Interface
REQ-001 SHALL have parameter TARGET, default 12'd512: desired |level|, unsigned.
REQ-002 SHALL have parameter HYST, default 12'd32: in-window half-width, unsigned.
REQ-003 SHALL have parameter LOCK_COUNT, default 4: consecutive in-window updates needed to lock, range 1..15.
REQ-004 SHALL have port ip_clock, input, 1: single clock; all state updates on the falling edge.
REQ-005 SHALL have port ip_reset, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port ip_sum, input, 12: signed accumulated level from the accumulator stage.
REQ-007 SHALL have port ip_sum_valid, input, 1: ip_sum is sampled on this cycle.
REQ-008 SHALL have port ip_data, input, 12: signed sample to be scaled.
REQ-009 SHALL have port op_data, output, 12: signed scaled, saturated sample.
REQ-010 SHALL have port op_gain, output, 6: unsigned Q2.4 gain code; 16 = unity.
REQ-011 SHALL have port op_locked, output, 1: high while in LOCKED.

Function
REQ-012 SHALL compute level = |ip_sum| in 13 bits unsigned, so -2048 -> 2048 with no wrap.
REQ-013 SHALL implement states IDLE, TRACK and LOCKED.
REQ-014 IDLE: SHALL move to TRACK on the first ip_sum_valid, with no gain change on that cycle.
REQ-015 TRACK with valid: level > TARGET+HYST SHALL decrement gain; level < TARGET-HYST SHALL increment gain; otherwise SHALL increment the lock counter.
REQ-016 TRACK: any out-of-window update SHALL clear the lock counter.
REQ-017 TRACK: when the lock counter reaches LOCK_COUNT, SHALL enter LOCKED on the next edge and clear the counter.
REQ-018 LOCKED: gain SHALL be frozen.
REQ-019 LOCKED: SHALL return to TRACK only when a valid level lies outside TARGET±2*HYST; that update SHALL also apply the inc/dec.
REQ-020 Gain SHALL saturate at 1 (min) and 63 (max); an inc at 63 or a dec at 1 SHALL hold the value.
REQ-021 SHALL ignore ip_sum when ip_sum_valid is low; no state or gain change.
REQ-022 SHALL compute op_data = sat12((ip_data * op_gain) >>> 4) using an 18-bit signed product.
REQ-023 op_data SHALL be registered with exactly 1 cycle latency from ip_data.
REQ-024 op_data SHALL clip to +2047 and -2048.
REQ-025 A gain change SHALL take effect on the op_data computed in the cycle after the update.
REQ-026 The TARGET±HYST comparisons SHALL be performed in 13 bits; TARGET < HYST SHALL clamp the lower bound to 0.

Reset
REQ-027 Asserting ip_reset low SHALL immediately force: state IDLE, op_gain = 16, lock counter 0, op_data 0, op_locked 0.
REQ-028 Reset asserted mid-operation SHALL discard all history; after release the block SHALL behave exactly as from power-up.

Configuration
REQ-029 With AGC_SAT_FLAG_EN defined, SHALL add output op_sat (1 bit), registered alongside op_data, high for each cycle whose op_data was clipped, reset 0.
REQ-030 Without AGC_SAT_FLAG_EN, the op_sat port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-031 Package agc_pkg SHALL hold the state enum, GAIN_UNITY=16, GAIN_MIN=1, GAIN_MAX=63 and the 12-bit saturation limits.
REQ-032 Multiply, shift and saturation SHALL be in sub-module agc_sat_mult: combinational, ports for data, gain, result and clip flag.

Verification
REQ-033 Reset release, ip_data=100 constant -> op_data=100, op_gain=16, op_locked=0.
REQ-034 ip_sum=1024 valid each cycle -> op_gain 16,15,14,... down to 1, then holds at 1.
REQ-035 ip_sum=-100 valid repeatedly -> op_gain rises to 63 and holds; with ip_data=2000 -> op_data=2047 (op_sat=1 if AGC_SAT_FLAG_EN is defined).
REQ-036 ip_sum=520 for 1 valid (IDLE->TRACK) then 4 valids -> op_locked=1 after the 4th; then ip_sum=560 -> stays locked; then ip_sum=600 -> TRACK with gain decremented.
REQ-037 ip_data=-2048, gain 32 -> op_data=-2048 clipped; ip_data=-1000 -> op_data=-2000, one cycle later.
REQ-038 ip_reset pulsed low while LOCKED with gain 9 -> outputs immediately op_gain=16, op_locked=0, op_data=0.

Source files
------------

// File: rtl/agc_pkg.sv
`default_nettype none
// ============================================================================
// agc_pkg : shared state encoding, gain limits and 12-bit saturation limits
// Rev 1.0
// ============================================================================
package agc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } agc_state_t;

  localparam logic [5:0] GAIN_UNITY = 6'd16;
  localparam logic [5:0] GAIN_MIN   = 6'd1;
  localparam logic [5:0] GAIN_MAX   = 6'd63;

  localparam logic signed [11:0] SAT_MAX = 12'sd2047;
  localparam logic signed [11:0] SAT_MIN = -12'sd2048;

  // Magnitude widened to 13 bits so that -2048 maps to 2048 without wrapping.
  function automatic logic [12:0] abs13(input logic signed [11:0] v);
    logic [12:0] ext;
    ext = {v[11], v};
    return v[11] ? (13'd0 - ext) : ext;
  endfunction

endpackage
`default_nettype wire

// File: rtl/agc_sat_mult.sv
`default_nettype none
// ============================================================================
// agc_sat_mult : combinational Q2.4 gain multiply, >>>4 and 12-bit saturation
// Rev 1.0
// ============================================================================
module agc_sat_mult
  import agc_pkg::*;
(
  input  logic signed [11:0] i_data,
  input  logic [5:0]         i_gain,
  output logic signed [11:0] o_result,
  output logic               o_clip
);

  logic signed [17:0] w_data_ext;
  logic signed [17:0] w_gain_ext;
  logic signed [17:0] w_prod;
  logic signed [17:0] w_shift;
  logic signed [17:0] w_hi;
  logic signed [17:0] w_lo;

  // |2048 * 63| < 2^17, so the 18-bit signed product never overflows.
  assign w_data_ext = {{6{i_data[11]}}, i_data};
  assign w_gain_ext = {12'd0, i_gain};
  assign w_prod     = w_data_ext * w_gain_ext;
  assign w_shift    = w_prod >>> 4;
  assign w_hi       = {{6{SAT_MAX[11]}}, SAT_MAX};
  assign w_lo       = {{6{SAT_MIN[11]}}, SAT_MIN};

  always_comb begin
    o_result = w_shift[11:0];
    o_clip   = 1'b0;
    if (w_shift > w_hi) begin
      o_result = SAT_MAX;
      o_clip   = 1'b1;
    end else if (w_shift < w_lo) begin
      o_result = SAT_MIN;
      o_clip   = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/agc_gain_ctrl.sv
`default_nettype none
// ============================================================================
// agc_gain_ctrl : level-tracking AGC with lock hysteresis and saturating scaler
// Optional op_sat clip flag enabled by defining AGC_SAT_FLAG_EN.   Rev 1.0
// ============================================================================
module agc_gain_ctrl
  import agc_pkg::*;
#(
  parameter logic [11:0] TARGET     = 12'd512,
  parameter logic [11:0] HYST       = 12'd32,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic               ip_clock,
  input  logic               ip_reset,
  input  logic signed [11:0] ip_sum,
  input  logic               ip_sum_valid,
  input  logic signed [11:0] ip_data,
  output logic signed [11:0] op_data,
  output logic [5:0]         op_gain,
  output logic               op_locked
`ifdef AGC_SAT_FLAG_EN
  ,
  output logic               op_sat
`endif
);

  localparam logic [12:0] c_tgt       = {1'b0, TARGET};
  localparam logic [12:0] c_hyst      = {1'b0, HYST};
  localparam logic [12:0] c_hyst2     = {HYST, 1'b0};
  localparam logic [12:0] c_win_hi    = c_tgt + c_hyst;
  localparam logic [12:0] c_win_lo    = (c_tgt < c_hyst) ? 13'd0 : (c_tgt - c_hyst);
  localparam logic [12:0] c_relock_hi = c_tgt + c_hyst2;
  localparam logic [12:0] c_relock_lo = (c_tgt < c_hyst2) ? 13'd0 : (c_tgt - c_hyst2);
  localparam logic [3:0]  c_lock_cnt  = 4'(LOCK_COUNT);

  agc_state_t         r_state;
  agc_state_t         w_state_nxt;
  logic [5:0]         r_gain;
  logic [5:0]         w_gain_nxt;
  logic [3:0]         r_lock_cnt;
  logic [3:0]         w_lock_cnt_nxt;
  logic signed [11:0] r_data;
  logic signed [11:0] w_result;
  logic [12:0]        w_level;
  logic               w_above;
  logic               w_below;
  logic               w_far_above;
  logic               w_far_below;
  logic [5:0]         w_gain_inc;
  logic [5:0]         w_gain_dec;

  assign w_level     = abs13(ip_sum);
  assign w_above     = w_level > c_win_hi;
  assign w_below     = w_level < c_win_lo;
  assign w_far_above = w_level > c_relock_hi;
  assign w_far_below = w_level < c_relock_lo;
  assign w_gain_inc  = (r_gain < GAIN_MAX) ? (r_gain + 6'd1) : r_gain;
  assign w_gain_dec  = (r_gain > GAIN_MIN) ? (r_gain - 6'd1) : r_gain;

  always_comb begin
    w_state_nxt    = r_state;
    w_gain_nxt     = r_gain;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      ST_IDLE: begin
        if (ip_sum_valid) begin
          w_state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        // A full lock counter promotes on the following edge; a sample on that edge is not used.
        if (r_lock_cnt == c_lock_cnt) begin
          w_state_nxt    = ST_LOCKED;
          w_lock_cnt_nxt = 4'd0;
        end else if (ip_sum_valid) begin
          if (w_above) begin
            w_gain_nxt     = w_gain_dec;
            w_lock_cnt_nxt = 4'd0;
          end else if (w_below) begin
            w_gain_nxt     = w_gain_inc;
            w_lock_cnt_nxt = 4'd0;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + 4'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (ip_sum_valid && w_far_above) begin
          w_gain_nxt  = w_gain_dec;
          w_state_nxt = ST_TRACK;
        end else if (ip_sum_valid && w_far_below) begin
          w_gain_nxt  = w_gain_inc;
          w_state_nxt = ST_TRACK;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_lock_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(negedge ip_clock or negedge ip_reset) begin
    if (!ip_reset) begin
      r_state    <= ST_IDLE;
      r_gain     <= GAIN_UNITY;
      r_lock_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_gain     <= w_gain_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

`ifdef AGC_SAT_FLAG_EN
  logic w_clip;
  logic r_sat;
`endif

  agc_sat_mult u_sat_mult (
    .i_data   (ip_data),
    .i_gain   (r_gain),
    .o_result (w_result),
`ifdef AGC_SAT_FLAG_EN
    .o_clip   (w_clip)
`else
    .o_clip   ()
`endif
  );

  always_ff @(negedge ip_clock or negedge ip_reset) begin
    if (!ip_reset) begin
      r_data <= 12'sd0;
    end else begin
      r_data <= w_result;
    end
  end

`ifdef AGC_SAT_FLAG_EN
  always_ff @(negedge ip_clock or negedge ip_reset) begin
    if (!ip_reset) begin
      r_sat <= 1'b0;
    end else begin
      r_sat <= w_clip;
    end
  end

  assign op_sat = r_sat;
`endif

  assign op_data   = r_data;
  assign op_gain   = r_gain;
  assign op_locked = (r_state == ST_LOCKED);

endmodule
`default_nettype wire
